// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter for 16 requesters with registered one-hot grant, encoded index,
// optional hold timeout and a configurable idle gap between release and re-arbitration.
module rr_arbiter_16 #(
    parameter int unsigned MaxHold   = 0,
    parameter int unsigned GapCycles = 1,
    parameter int unsigned HoldW     = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic [15:0] req_i,
    output logic [15:0] gnt_o,
    output logic [3:0]  gnt_idx_o,
    output logic        gnt_valid_o,
    output logic        timeout_pulse_o
);

    localparam int unsigned GapW = (GapCycles > 1) ? $clog2(GapCycles) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       gnt_q, gnt_d;
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        ptr_q, ptr_d;
    logic [HoldW-1:0]  hold_q, hold_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic              pulse_q, pulse_d;

    logic [3:0]        winner;
    logic              any_req;

    // Scan from ptr upward with 4-bit wrap; the first asserted request wins.
    always_comb begin
        logic [3:0] cand;
        logic       found;
        cand   = '0;
        found  = 1'b0;
        winner = ptr_q;
        for (int i = 0; i < 16; i++) begin
            cand = ptr_q + 4'(i);
            if (!found && req_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign any_req = |req_i;

    always_comb begin
        logic release_now;
        state_d     = state_q;
        gnt_d       = gnt_q;
        idx_d       = idx_q;
        ptr_d       = ptr_q;
        hold_d      = hold_q;
        gap_d       = gap_q;
        pulse_d     = 1'b0;
        release_now = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (enable_i && any_req) begin
                    gnt_d   = 16'h0001 << winner;
                    idx_d   = winner;
                    ptr_d   = winner + 4'd1;
                    hold_d  = HoldW'(1);
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!req_i[idx_q]) begin
                    release_now = 1'b1;
                end else if ((MaxHold != 0) && (hold_q == HoldW'(MaxHold))) begin
                    release_now = 1'b1;
                    pulse_d     = 1'b1;
                end else if (hold_q != {HoldW{1'b1}}) begin
                    hold_d = hold_q + 1'b1;
                end
                if (release_now) begin
                    gnt_d   = '0;
                    gap_d   = '0;
                    state_d = (GapCycles > 0) ? StGap : StIdle;
                end
            end
            StGap: begin
                if (gap_q == GapW'(GapCycles - 1)) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            gap_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            pulse_q <= pulse_d;
        end
    end

    assign gnt_o           = gnt_q;
    assign gnt_idx_o       = idx_q;
    assign gnt_valid_o     = |gnt_q;
    assign timeout_pulse_o = pulse_q;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Scoreboard bench for rr_arbiter_16: directed scenarios plus random traffic, with expected
// outputs produced by a cycle-level reference model of the arbitration rules.
module tb_rr_arbiter_16;

    localparam int TbMaxHold = 4;
    localparam int TbGap     = 1;
    localparam int TbHoldW   = 8;

    typedef struct packed {
        logic [15:0] gnt;
        logic [3:0]  idx;
        logic        valid;
        logic        pulse;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] req = '0;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic        timeout_pulse;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;
    bit done = 1'b0;
    bit cap = 1'b0;
    exp_t exp_q[$];
    int obs_q[$];

    // Reference model state: owner -1 means no grant.
    int m_owner = -1;
    int m_idx = 0;
    int m_ptr = 0;
    int m_hold = 0;
    int m_gap = 0;
    bit m_pulse = 1'b0;

    rr_arbiter_16 #(
        .MaxHold  (TbMaxHold),
        .GapCycles(TbGap),
        .HoldW    (TbHoldW)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .enable_i       (enable),
        .req_i          (req),
        .gnt_o          (gnt),
        .gnt_idx_o      (gnt_idx),
        .gnt_valid_o    (gnt_valid),
        .timeout_pulse_o(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input logic [15:0] q);
        int c;
        if (r) begin
            m_owner = -1;
            m_idx   = 0;
            m_ptr   = 0;
            m_hold  = 0;
            m_gap   = 0;
            m_pulse = 1'b0;
            return;
        end
        m_pulse = 1'b0;
        if (m_owner >= 0) begin
            if (!q[m_owner]) begin
                m_owner = -1;
                m_gap   = TbGap;
            end else if (TbMaxHold != 0 && m_hold == TbMaxHold) begin
                m_owner = -1;
                m_gap   = TbGap;
                m_pulse = 1'b1;
            end else if (m_hold < (1 << TbHoldW) - 1) begin
                m_hold++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (e && q != 16'h0) begin
            for (int k = 0; k < 16; k++) begin
                c = (m_ptr + k) % 16;
                if (q[c]) begin
                    m_owner = c;
                    m_idx   = c;
                    m_ptr   = (c + 1) % 16;
                    m_hold  = 1;
                    break;
                end
            end
        end
    endtask

    // One clock of stimulus: drive at negedge and queue what the next edge must produce.
    task automatic cyc(input bit r, input bit e, input logic [15:0] q);
        exp_t ex;
        @(negedge clk);
        reset  = r;
        enable = e;
        req    = q;
        model_step(r, e, q);
        ex.gnt   = (m_owner >= 0) ? (16'h0001 << m_owner) : 16'h0;
        ex.idx   = 4'(m_idx);
        ex.valid = (m_owner >= 0);
        ex.pulse = m_pulse;
        exp_q.push_back(ex);
        started = 1'b1;
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against the queued expectation.
    initial begin
        exp_t ex;
        logic prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                chk("gnt", 32'(gnt), 32'(ex.gnt));
                chk("gnt_idx", 32'(gnt_idx), 32'(ex.idx));
                chk("gnt_valid", 32'(gnt_valid), 32'(ex.valid));
                chk("timeout_pulse", 32'(timeout_pulse), 32'(ex.pulse));
                chk("onehot", 32'($countones(gnt) <= 1), 32'(1));
                if (cap && gnt_valid && !prev_valid) obs_q.push_back(int'(gnt_idx));
            end else if (started && !done) begin
                chk("scoreboard_underrun", 32'(exp_q.size()), 32'(1));
            end
            prev_valid = gnt_valid;
        end
    end

    initial begin
        logic [15:0] rq;
        logic [31:0] rnd;

        // 1: reset, then single requester 0
        cyc(1, 1, 16'h0000);
        cyc(1, 1, 16'h0000);
        cyc(0, 1, 16'h0001);
        cyc(0, 1, 16'h0001);
        repeat (4) cyc(0, 1, 16'h0000);

        // 2: all requesting, each owner drops after 3 grant cycles
        cyc(1, 1, 16'hFFFF);
        obs_q.delete();
        cap = 1'b1;
        repeat (88) begin
            rq = 16'hFFFF;
            if (m_owner >= 0 && m_hold >= 3) rq[m_owner] = 1'b0;
            cyc(0, 1, rq);
        end
        cap = 1'b0;
        chk("order_count", 32'(obs_q.size() >= 17), 32'(1));
        for (int k = 0; k < 17 && k < obs_q.size(); k++) begin
            chk("order_idx", 32'(obs_q[k]), 32'(k % 16));
        end
        repeat (3) cyc(0, 1, 16'h0000);

        // 3: wrap-around from ptr=15
        cyc(1, 1, 16'h0000);
        cyc(0, 1, 16'h4000);
        repeat (3) cyc(0, 1, 16'h0000);
        repeat (2) cyc(0, 1, 16'h8001);
        repeat (5) cyc(0, 1, 16'h0001);
        repeat (3) cyc(0, 1, 16'h0000);

        // 4: hold timeout alternates between requesters 4 and 5
        repeat (16) cyc(0, 1, 16'h0030);
        repeat (3) cyc(0, 1, 16'h0000);

        // 5: enable low keeps current grant but blocks new ones
        cyc(0, 1, 16'h0004);
        repeat (2) cyc(0, 0, 16'h0004);
        repeat (5) cyc(0, 0, 16'h0100);
        repeat (2) cyc(0, 1, 16'h0100);
        repeat (3) cyc(0, 1, 16'h0000);

        // 6: reset mid-grant
        repeat (2) cyc(0, 1, 16'h0080);
        cyc(1, 1, 16'h0080);
        repeat (2) cyc(0, 1, 16'h0081);
        repeat (3) cyc(0, 1, 16'h0000);

        // Random traffic with sticky requests
        rq = 16'h0;
        repeat (800) begin
            if ($urandom_range(0, 3) == 0) begin
                rnd = $urandom();
                rq  = rnd[15:0] & ((($urandom_range(0, 1)) != 0) ? 16'hFFFF : 16'h0F0F);
            end
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), rq);
        end

        @(negedge clk);
        done = 1'b1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
